// File: rtl/multu_seq_pkg.sv
// Shared constants for the sequential multiplier.
// Optional signed (MULT) support is enabled by defining MULTU_SEQ_SIGNED_EN.
package multu_seq_pkg;

   // Default operand width, kept equal to the divider's default width.
   localparam int MULTU_SEQ_WIDTH = 32;

   // One shift-add iteration per operand bit.
   localparam int MULTU_SEQ_ITER = MULTU_SEQ_WIDTH;

   // FSM encoding: IDLE holds results, RUN iterates, FIX negates a signed result.
   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_RUN  = 2'd1;
   localparam state_t ST_FIX  = 2'd2;

endpackage

// File: rtl/multu_seq_step.sv
// One radix-2 shift-add iteration: conditionally add the multiplicand into the
// upper half, then shift the {carry, upper, lower} chain right by one bit.
module multu_seq_step
   import multu_seq_pkg::*;
#(
   parameter int WIDTH = MULTU_SEQ_WIDTH
) (
   input  logic [WIDTH-1:0] hi_in,
   input  logic [WIDTH-1:0] lo_in,
   input  logic [WIDTH-1:0] mcand,
   output logic [WIDTH:0]   acc_out,
   output logic [WIDTH-1:0] lo_out
);

   logic [WIDTH:0] sum;

   // Add the multiplicand when the current multiplier bit is set; the carry
   // out of the add becomes the top bit of the shifted upper half.
   always_comb begin
      sum     = {1'b0, hi_in} + (lo_in[0] ? {1'b0, mcand} : '0);
      acc_out = {1'b0, sum[WIDTH:1]};
      lo_out  = {sum[0], lo_in[WIDTH-1:1]};
   end

endmodule

// File: rtl/multu_seq.sv
// Sequential 32x32->64 multiplier (radix-2 shift-add, one bit per clock) with
// the same start/busy/done handshake as the iterative divider.
// start: level-sampled on every rising edge; when high it aborts any operation
// in flight and loads new operands. busy is high while an operation is in
// progress; done pulses for exactly one cycle when hi/lo first hold a result.
// Define MULTU_SEQ_SIGNED_EN to add the signed_op port and signed MULT support.
module multu_seq
   import multu_seq_pkg::*;
#(
   parameter int WIDTH = MULTU_SEQ_WIDTH
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] multiplicand,
   input  logic [WIDTH-1:0] multiplier,
`ifdef MULTU_SEQ_SIGNED_EN
   input  logic             signed_op,
`endif
   input  logic             start,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done
);

   localparam logic [5:0] LAST_CNT = 6'(WIDTH - 1);

   logic [WIDTH:0]   acc;
   logic [WIDTH-1:0] mcand;
   logic [5:0]       cnt;
   state_t           state;

   logic [WIDTH:0]   step_acc;
   logic [WIDTH-1:0] step_lo;
   logic [WIDTH-1:0] a_load;
   logic [WIDTH-1:0] b_load;

   // The carry bit of acc is always cleared by the shift; only hi is visible.
   logic unused_carry;
   assign unused_carry = acc[WIDTH];
   assign hi           = acc[WIDTH-1:0];

   multu_seq_step #(.WIDTH(WIDTH)) u_step (
      .hi_in   (acc[WIDTH-1:0]),
      .lo_in   (lo),
      .mcand   (mcand),
      .acc_out (step_acc),
      .lo_out  (step_lo)
   );

`ifdef MULTU_SEQ_SIGNED_EN
   logic                 neg;
   logic                 neg_load;
   logic [2*WIDTH-1:0]   neg_prod;

   // Signed operands are multiplied as magnitudes; the most-negative value
   // maps onto itself, which is its correct unsigned magnitude.
   always_comb begin
      a_load   = (signed_op && multiplicand[WIDTH-1]) ? -multiplicand : multiplicand;
      b_load   = (signed_op && multiplier[WIDTH-1])   ? -multiplier   : multiplier;
      neg_load = signed_op & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
      neg_prod = -{acc[WIDTH-1:0], lo};
   end
`else
   // Unsigned only: operands load as-is.
   always_comb begin
      a_load = multiplicand;
      b_load = multiplier;
   end
`endif

   // Control FSM plus the iteration registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         acc   <= '0;
         lo    <= '0;
         mcand <= '0;
         cnt   <= '0;
         state <= ST_IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
`ifdef MULTU_SEQ_SIGNED_EN
         neg   <= 1'b0;
`endif
      end else if (start) begin
         acc   <= '0;
         lo    <= b_load;
         mcand <= a_load;
         cnt   <= '0;
         state <= ST_RUN;
         busy  <= 1'b1;
         done  <= 1'b0;
`ifdef MULTU_SEQ_SIGNED_EN
         neg   <= neg_load;
`endif
      end else begin
         case (state)
            ST_RUN: begin
               acc  <= step_acc;
               lo   <= step_lo;
               cnt  <= cnt + 6'd1;
               done <= 1'b0;
               if (cnt == LAST_CNT) begin
`ifdef MULTU_SEQ_SIGNED_EN
                  if (neg) begin
                     state <= ST_FIX;
                  end else begin
                     state <= ST_IDLE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end
`else
                  state <= ST_IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
`endif
               end
            end
`ifdef MULTU_SEQ_SIGNED_EN
            ST_FIX: begin
               acc   <= {1'b0, neg_prod[2*WIDTH-1:WIDTH]};
               lo    <= neg_prod[WIDTH-1:0];
               state <= ST_IDLE;
               busy  <= 1'b0;
               done  <= 1'b1;
            end
`endif
            default: begin
               done <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_multu_seq.sv
// Self-checking bench for multu_seq: directed corner cases, restart, reset
// mid-operation and randomized back-to-back operations against a plain
// arithmetic reference. Signed cases are compiled in with MULTU_SEQ_SIGNED_EN.
module tb_multu_seq;

   localparam int W = 32;

   logic          clock = 1'b0;
   logic          reset;
   logic          start;
   logic [W-1:0]  multiplicand;
   logic [W-1:0]  multiplier;
   logic          sig_op;
   logic [W-1:0]  hi;
   logic [W-1:0]  lo;
   logic          busy;
   logic          done;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [2*W-1:0] exp_q[$];
   int             lat_q[$];

   multu_seq #(.WIDTH(W)) dut (
      .clock        (clock),
      .reset        (reset),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
`ifdef MULTU_SEQ_SIGNED_EN
      .signed_op    (sig_op),
`endif
      .start        (start),
      .hi           (hi),
      .lo           (lo),
      .busy         (busy),
      .done         (done)
   );

   // clock / watchdog
   always #5 clock = ~clock;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, tests_run=%0d", tests_run);
      $fatal(1, "watchdog expired");
   end

   // checker
   task automatic check_val(input string tag, input logic [2*W-1:0] got,
                            input logic [2*W-1:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // reference model
   function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] a,
                                               input logic [W-1:0] b,
                                               input logic s);
      logic signed [2*W-1:0] sa;
      logic signed [2*W-1:0] sb;
      if (s) begin
         sa = {{W{a[W-1]}}, a};
         sb = {{W{b[W-1]}}, b};
         return sa * sb;
      end
      return {{W{1'b0}}, a} * {{W{1'b0}}, b};
   endfunction

   function automatic int ref_lat(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic s);
      return (s && (a[W-1] ^ b[W-1])) ? W + 1 : W;
   endfunction

   // drivers (called at a falling edge; return at the falling edge after T0)
   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
      multiplicand = a;
      multiplier   = b;
      sig_op       = s;
      start        = 1'b1;
      exp_q.delete();
      lat_q.delete();
      exp_q.push_back(ref_prod(a, b, s));
      lat_q.push_back(ref_lat(a, b, s));
      @(negedge clock);
      start = 1'b0;
      check_val("start_busy", 64'(busy), 64'd1);
      check_val("start_done_clr", 64'(done), 64'd0);
   endtask

   task automatic finish_op(input string tag);
      int n;
      logic [2*W-1:0] exp;
      int lat;
      n = 0;
      while (busy && n < 200) begin
         n++;
         @(negedge clock);
      end
      check_val({tag, "_qsize"}, 64'(exp_q.size()), 64'd1);
      if (exp_q.size() > 0) begin
         exp = exp_q.pop_front();
         lat = lat_q.pop_front();
         check_val({tag, "_latency"}, 64'(n), 64'(lat));
         check_val({tag, "_done"}, 64'(done), 64'd1);
         check_val({tag, "_prod"}, {hi, lo}, exp);
      end
   endtask

   task automatic hold_check(input string tag);
      logic [2*W-1:0] prev;
      prev = {hi, lo};
      @(negedge clock);
      check_val({tag, "_done_pulse"}, 64'(done), 64'd0);
      check_val({tag, "_hold"}, {hi, lo}, prev);
      check_val({tag, "_idle"}, 64'(busy), 64'd0);
   endtask

   task automatic run_op(input string tag, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic s);
      issue(a, b, s);
      finish_op(tag);
      hold_check(tag);
   endtask

   // main sequence
   initial begin
      int done_cnt;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic rs;

      reset        = 1'b1;
      start        = 1'b0;
      multiplicand = '0;
      multiplier   = '0;
      sig_op       = 1'b0;
      repeat (3) @(negedge clock);
      check_val("reset_busy", 64'(busy), 64'd0);
      check_val("reset_done", 64'(done), 64'd0);
      check_val("reset_hilo", {hi, lo}, 64'd0);
      reset = 1'b0;
      @(negedge clock);

      // directed unsigned cases
      run_op("u3x5",   32'd3,          32'd5,          1'b0);
      run_op("umax",   32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0);
      run_op("uzero_b", 32'h1234_5678, 32'd0,          1'b0);
      run_op("uzero_a", 32'd0,         32'hFFFF_FFFF,  1'b0);
      run_op("umsb",   32'h8000_0000,  32'h8000_0000,  1'b0);

      // restart: second start ten cycles after the first
      issue(32'd7, 32'd9, 1'b0);
      done_cnt = 0;
      repeat (9) begin
         @(negedge clock);
         if (done) done_cnt++;
      end
      check_val("restart_no_done", 64'(done_cnt), 64'd0);
      issue(32'd2, 32'd3, 1'b0);
      finish_op("restart");
      hold_check("restart");

      // reset during an operation
      issue(32'h0001_0000, 32'h0001_0000, 1'b0);
      repeat (13) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      exp_q.delete();
      lat_q.delete();
      check_val("midreset_busy", 64'(busy), 64'd0);
      check_val("midreset_done", 64'(done), 64'd0);
      check_val("midreset_hilo", {hi, lo}, 64'd0);
      run_op("after_reset", 32'h0001_0000, 32'h0001_0000, 1'b0);

`ifdef MULTU_SEQ_SIGNED_EN
      run_op("s_neg3x5",  32'hFFFF_FFFD, 32'd5,         1'b1);
      run_op("s_minxmin", 32'h8000_0000, 32'h8000_0000, 1'b1);
      run_op("s_minx1",   32'h8000_0000, 32'd1,         1'b1);
      run_op("s_neg0",    32'hFFFF_FFFD, 32'd0,         1'b1);
      run_op("s_negneg",  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
      run_op("s_unsmode", 32'hFFFF_FFFD, 32'd5,         1'b0);
`endif

      // randomized operations, often back-to-back in the done cycle
      for (int i = 0; i < 24; i++) begin
         ra = $urandom();
         rb = $urandom();
         case ($urandom_range(0, 3))
            0: ra = ra & 32'h0000_00FF;
            1: rb = rb | 32'h8000_0000;
            default: ;
         endcase
`ifdef MULTU_SEQ_SIGNED_EN
         rs = 1'($urandom_range(0, 1));
`else
         rs = 1'b0;
`endif
         issue(ra, rb, rs);
         finish_op("rand");
         if ($urandom_range(0, 1) == 1) hold_check("rand");
      end
      hold_check("final");

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
